// File: rtl/issue_scheduler.sv
// Issue controller for the 16-bit pipeline: routes decoded instructions to the
// 1-stage ALU or 4-stage multiplier path, stalling on RAW/WAW and write-port collisions.
module issue_scheduler #(
  parameter int ALU_LAT = 2,
  parameter int MUL_LAT = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [15:0]      dec_instr,
  output logic             stall,
  output logic             issue_alu,
  output logic             issue_mul,
  output logic             illegal,
  output logic             wb_valid,
  output logic [3:0]       wb_dest,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [2:0] ALU_L3 = 3'(ALU_LAT);
  localparam logic [2:0] MUL_L3 = 3'(MUL_LAT);

  logic [3:0] op, rd, rs1, rs2;
  logic       is_alu_reg, is_alu_imm, is_alu, is_mul, is_ill, is_nop;
  logic       raw, waw, collide;

  logic [2:0]       pend [16];
  // One spare slot above the multiplier insert point so its collision check has a real slot to read.
  logic [MUL_LAT:0] wb_sched;
  logic [3:0]       wb_tag [MUL_LAT+1];

  assign op  = dec_instr[15:12];
  assign rd  = dec_instr[11:8];
  assign rs1 = dec_instr[7:4];
  assign rs2 = dec_instr[3:0];

  always_comb begin
    is_alu_reg = 1'b0;
    is_alu_imm = 1'b0;
    is_mul     = 1'b0;
    is_ill     = 1'b0;
    case (op)
      4'h1, 4'h2, 4'h4, 4'h5, 4'h6:       is_alu_reg = 1'b1;
      4'h3, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: is_alu_imm = 1'b1;
      4'hC:                               is_mul     = 1'b1;
      4'hD, 4'hE, 4'hF:                   is_ill     = 1'b1;
      default: ;
    endcase
  end

  assign is_alu = is_alu_reg | is_alu_imm;
  assign is_nop = ~(is_alu | is_mul);

  // Immediate ops carry the immediate in [7:4], so rs1 is only checked for register forms.
  assign raw     = (pend[rs2] != 3'd0) | ((is_alu_reg | is_mul) & (pend[rs1] != 3'd0));
  assign waw     = (pend[rd] != 3'd0);
  assign collide = is_alu ? wb_sched[ALU_LAT] : wb_sched[MUL_LAT];

  assign stall     = dec_valid & ~is_nop & (raw | waw | collide);
  assign issue_alu = dec_valid & is_alu & ~stall;
  assign issue_mul = dec_valid & is_mul & ~stall;

  assign wb_valid = wb_sched[0];
  assign wb_dest  = wb_tag[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 16; r++) pend[r] <= 3'd0;
      for (int k = 0; k <= MUL_LAT; k++) wb_tag[k] <= 4'd0;
      wb_sched    <= '0;
      stall_count <= '0;
      illegal     <= 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) begin
        if ((issue_alu | issue_mul) && (rd == 4'(r)))
          pend[r] <= issue_mul ? MUL_L3 : ALU_L3;
        else if (pend[r] != 3'd0)
          pend[r] <= pend[r] - 3'd1;
      end

      for (int k = 0; k < MUL_LAT; k++) begin
        wb_sched[k] <= wb_sched[k+1];
        wb_tag[k]   <= wb_tag[k+1];
      end
      wb_sched[MUL_LAT] <= 1'b0;
      wb_tag[MUL_LAT]   <= 4'd0;
      if (issue_alu) begin
        wb_sched[ALU_LAT-1] <= 1'b1;
        wb_tag[ALU_LAT-1]   <= rd;
      end
      if (issue_mul) begin
        wb_sched[MUL_LAT-1] <= 1'b1;
        wb_tag[MUL_LAT-1]   <= rd;
      end

      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;

      illegal <= dec_valid & is_ill;
    end
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Issue controller between the decode stage and the two execution paths of the 16-bit pipeline: the 1-stage ALU path and the 4-stage multiplier path (opcode 1100).
- Each cycle it decides whether the decoded instruction may issue, and to which path.
- It stalls fetch/decode on RAW or WAW hazards and on writeback-port collisions, since both paths share the single register-file write port.
- It also reports the writeback schedule and a saturating stall counter.

Parameters:
- ALU_LAT, 2, cycles from ALU issue to its writeback cycle.
- MUL_LAT, 5, cycles from MUL issue to its writeback cycle; must be greater than ALU_LAT.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock (the divided clock clk[25] at top level).
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode stage holds an instruction.
- dec_instr  in  16  decoded instruction: [15:12] opcode, [11:8] rd, [7:4] rs1/imm, [3:0] rs2.
- stall  out  1  hold PC, IRF and IRD this cycle (combinational).
- issue_alu  out  1  instruction issues to the ALU path this cycle (combinational).
- issue_mul  out  1  instruction issues to the multiplier path this cycle (combinational).
- illegal  out  1  registered pulse: opcode 1101–1111 was consumed.
- wb_valid  out  1  registered: a writeback occurs in this cycle.
- wb_dest  out  4  registered: destination of that writeback.
- stall_count  out  CNT_W  number of stalled cycles, saturating.

Behaviour:
- Decoding of dec_instr:
  - Instruction 16'h0000 is NOP: no sources, no writeback, always issues.
  - Opcodes 0001, 0010, 0100, 0101, 0110 are ALU register ops. Sources are rs1 and rs2.
  - Opcodes 0011, 0111, 1000, 1001, 1010, 1011 are ALU immediate ops. The only source is rs2; [7:4] is the immediate and is never hazard-checked.
  - Opcode 1100 is MUL. Sources are rs1 and rs2.
  - Opcode 0000 with nonzero lower bits is treated as NOP.
  - Opcodes 1101–1111 are consumed as NOP and raise illegal for 1 cycle.
- Scoreboard:
  - pend[r], r = 0..15, is a 3-bit countdown.
  - On issue with latency L and destination rd, pend[rd] <= L.
  - Otherwise each nonzero pend decrements by 1 per cycle.
  - A register is ready when pend == 0.
- Writeback schedule:
  - wb_sched[k], k = 0..MUL_LAT-1, means a writeback is scheduled k cycles from now; wb_tag[k] holds its rd.
  - Each edge shifts the schedule down by one slot.
  - An ALU issue inserts at slot ALU_LAT-1; a MUL issue inserts at slot MUL_LAT-1.
  - wb_valid/wb_dest are driven from slot 0.
- Stall conditions, evaluated only when dec_valid = 1 and the instruction is not a NOP:
  - RAW: any source has pend != 0.
  - WAW: pend[rd] != 0.
  - Port collision, ALU: the slot the ALU writeback would land in is already taken, i.e. wb_sched[ALU_LAT] == 1 before the shift.
  - Port collision, MUL: the corresponding MUL slot is already taken; this is structurally impossible but must still be checked.
- Issue outputs:
  - issue_alu = dec_valid & ALU-class & !stall.
  - issue_mul = dec_valid & MUL & !stall.
  - At most one of issue_alu/issue_mul is high in any cycle.
  - NOPs and illegal opcodes never set pend or wb_sched.
- rd = 0 is tracked like any other register; no hardwired zero.
- stall_count increments on every cycle with stall = 1 and holds at all-ones.
- Reset:
  - On the clk edge with reset = 1, all pend and wb_sched entries are cleared, stall_count = 0, wb_valid = 0, wb_dest = 0, illegal = 0.
  - In-flight operations are forgotten, because the datapath is flushed by the same reset.
  - The combinational outputs follow from the cleared state on the next cycle.
  - Reset mid-stall releases the stall on the first cycle after reset.
- Simultaneous events:
  - An issue whose rd equals a register reaching pend 1→0 in the same cycle is still a WAW stall, because the check uses the current pend.
  - The decrement and the reload of one entry never coincide, because WAW blocks it.

Test Plan:
- After reset, issue 0x1123 (add r1 = r2 + r3) → issue_alu = 1 in cycle 0, stall = 0; wb_valid = 1 with wb_dest = 1 exactly ALU_LAT cycles later.
- Issue MUL 0xC412, then ALU 0x1543 (reads r4) on the next cycle → stall = 1 for 4 cycles, issue_alu on cycle 5; stall_count = 4.
- Issue MUL 0xC512, then independent ALU 0x1623 three cycles later, so both writebacks would land in cycle 5 → ALU stalls exactly 1 cycle; wb_valid occurs in cycle 5 (rd = 5) and cycle 6 (rd = 6), never doubled.
- Issue MUL 0xC712, then ALU 0xA732 (addi to r7) → WAW stall until pend[7] = 0; the final wb_dest sequence is 7 (MUL), then 7 (ALU).
- Present 0xE000, then 0x0000 → illegal = 1 for one cycle after 0xE000; no wb_valid and no stall for either instruction.
- Start a MUL, then assert reset during its 2nd cycle → the cycle after reset has pend all 0, wb_valid = 0, stall_count = 0; a dependent instruction issues immediately.
